mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Single owner of the byte-wide RAM port.
- Arbitrates between instruction fetch (4-byte reads) and load/store (1/2/4-byte reads or writes).
- Serialises each word access into little-endian byte transfers, pipelines read returns against the one-cycle RAM read latency, and honours RAM back-pressure.
- Sits between the IF/MEM stages and the top-level RAM/IO interface.

Parameters:
- ADDR_W, 32, address width (matches MemAddrBus).
- DATA_W, 32, word width (matches MemDataBus); byte width fixed at 8.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, level; held until if_done.
- if_addr  in  32  fetch byte address.
- if_data  out  32  fetched word; valid when if_done is high, held until the next fetch completes.
- if_done  out  1  one-cycle completion pulse.
- ls_req  in  1  load/store request, level; held until ls_done.
- ls_write  in  1  1 = store, 0 = load.
- ls_length  in  3  byte count: 1, 2 or 4.
- ls_addr  in  32  load/store byte address.
- ls_wdata  in  32  store data; byte k = bits [8k+7:8k].
- ls_rdata  out  32  load data, zero-extended above length; valid with ls_done, held.
- ls_done  out  1  one-cycle completion pulse.
- ram_busy  in  1  RAM/IO cannot accept a transfer this cycle.
- ram_din  in  8  read byte; returns the cycle after the address was issued.
- ram_write  out  1  1 = write byte this cycle.
- ram_addr  out  32  byte address.
- ram_dout  out  8  write byte.

Behaviour:
- Reset values:
  - state = IDLE; all counters 0.
  - if_done, ls_done, ram_write = 0; ram_addr, ram_dout = 0.
  - if_data, ls_rdata = 0.
  - A reset mid-transaction aborts it: no done pulse, no further RAM traffic, partial data discarded.
- States:
  - IDLE, READ, WRITE.
  - Registers: owner (IF/LS), n (total bytes), issue count ic, capture count cc, pending (a read byte was issued last cycle).
- IDLE:
  - If done was pulsed this cycle, requests are ignored (one-cycle turnaround so the requester can drop req).
  - Otherwise ls_req has priority over if_req.
  - ls_write=1 -> WRITE, else -> READ; IF always -> READ with n=4.
  - Address, wdata and length are latched at acceptance; later input changes are ignored.
- Length handling:
  - 1, 2 and 4 are legal.
  - 0 completes with the done pulse on the next cycle and no RAM access.
  - 3 is executed as 3 bytes.
  - 5–7 are clamped to 4.
- READ:
  - ram_addr = base + ic (32-bit wrap); ram_write = 0.
  - A byte is issued when ic < n and !ram_busy; issuing increments ic and sets pending for the next cycle.
  - When pending is set, ram_din is captured into byte cc of the data register and cc increments.
  - Capture ignores ram_busy; issue and capture overlap, so throughput is 1 byte/cycle.
  - When cc reaches n: write the result to if_data or ls_rdata (upper bytes 0), move to IDLE, and pulse the owner's done in the following cycle.
- WRITE:
  - ram_write = !ram_busy; ram_addr = base + ic; ram_dout = byte ic of the latched wdata.
  - ic increments only on cycles where ram_write=1.
  - When ic reaches n: move to IDLE and pulse ls_done.
- Latency (request seen in IDLE at cycle A, no busy):
  - Read of n bytes: issues A+1..A+n; done high at A+n+2.
  - Write of n bytes: writes A+1..A+n; done high at A+n+1.
  - Each busy cycle adds one.
- No preemption: a fetch in flight completes even if ls_req rises. LS is then served on the cycle after if_done.
- Outside an active write, ram_write is 0.

Test Plan:
- Fetch, if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> issued addresses 0x100–0x103 on consecutive cycles; if_data=0x00100513; if_done one cycle at A+6.
- Store word: ls_addr=0x20, data 0xDEADBEEF, length 4 -> ram_write on 4 cycles with (0x20,EF),(0x21,BE),(0x22,AD),(0x23,DE); ls_done at A+5.
- Byte load: length 1 at 0x31, RAM returns 0x80 -> ls_rdata=0x00000080; exactly one RAM address issued.
- Simultaneous if_req and ls_req (store half 0x1234 at 0x40) -> store runs first: (0x40,34),(0x41,12), then ls_done, one turnaround cycle, then the fetch.
- ram_busy high for 2 cycles during the second byte of a 4-byte store -> no ram_write in those cycles; bytes stay in order; done is 2 cycles later.
- reset asserted mid-fetch after 2 bytes -> next cycle IDLE, if_done never pulses, ram_write=0; a new fetch completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM port controller arbitrating fetch and load/store
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_write,
  input  logic [2:0]        ls_length,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  input  logic              ram_busy,
  input  logic [7:0]        ram_din,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_ls_q, owner_ls_d;   // 1 = load/store owns the access, 0 = fetch
  logic [2:0]        n_q, n_d;                 // total bytes of the access
  logic [2:0]        ic_q, ic_d;               // bytes issued to the RAM
  logic [2:0]        cc_q, cc_d;               // read bytes captured
  logic              pending_q, pending_d;     // a read byte was issued last cycle
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] buf_q, buf_d;             // read bytes assembled so far
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  logic [2:0]        rd_off;
  logic              issue;

  // Lengths above a full word are clamped; 0 and 3 pass through unchanged.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    clamp_len = (len > 3'd4) ? 3'd4 : len;
  endfunction

  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;
  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;

  // Next-state, arbitration and RAM port drive.
  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    n_d        = n_q;
    ic_d       = ic_q;
    cc_d       = cc_q;
    pending_d  = pending_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    ram_write  = 1'b0;
    ram_addr   = '0;
    ram_dout   = '0;
    issue      = 1'b0;
    rd_off     = '0;

    case (state_q)
      S_IDLE: begin
        // The cycle a done pulse is high is a turnaround: the requester is still dropping req.
        if (!(if_done_q || ls_done_q)) begin
          if (ls_req) begin
            owner_ls_d = 1'b1;
            base_d     = ls_addr;
            wdata_d    = ls_wdata;
            n_d        = clamp_len(ls_length);
            ic_d       = '0;
            cc_d       = '0;
            pending_d  = 1'b0;
            buf_d      = '0;
            if (clamp_len(ls_length) == 3'd0) begin
              ls_done_d = 1'b1;
              if (!ls_write) ls_rdata_d = '0;
            end else begin
              state_d = ls_write ? S_WRITE : S_READ;
            end
          end else if (if_req) begin
            owner_ls_d = 1'b0;
            base_d     = if_addr;
            n_d        = 3'd4;
            ic_d       = '0;
            cc_d       = '0;
            pending_d  = 1'b0;
            buf_d      = '0;
            state_d    = S_READ;
          end
        end
      end

      S_READ: begin
        // Once every byte is issued, hold the last address rather than exposing base+n.
        rd_off    = (ic_q < n_q) ? ic_q : (n_q - 3'd1);
        ram_addr  = base_q + ADDR_W'(rd_off);
        issue     = (ic_q < n_q) && !ram_busy;
        pending_d = issue;
        if (issue) ic_d = ic_q + 3'd1;
        if (pending_q) begin
          buf_d = buf_q | (DATA_W'(ram_din) << {cc_q, 3'b000});
          cc_d  = cc_q + 3'd1;
          if ((cc_q + 3'd1) == n_q) begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
            if (owner_ls_q) begin
              ls_rdata_d = buf_d;
              ls_done_d  = 1'b1;
            end else begin
              if_data_d = buf_d;
              if_done_d = 1'b1;
            end
          end
        end
      end

      S_WRITE: begin
        ram_addr  = base_q + ADDR_W'(ic_q);
        ram_dout  = 8'(wdata_q >> {ic_q, 3'b000});
        ram_write = !ram_busy;
        if (!ram_busy) begin
          ic_d = ic_q + 3'd1;
          if ((ic_q + 3'd1) == n_q) begin
            state_d   = S_IDLE;
            ls_done_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any access in flight and clears returned data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_ls_q <= 1'b0;
      n_q        <= '0;
      ic_q       <= '0;
      cc_q       <= '0;
      pending_q  <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      n_q        <= n_d;
      ic_q       <= ic_d;
      cc_q       <= cc_d;
      pending_q  <= pending_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
    end
  end

endmodule
